// File: rtl/cond_branch_unit_pkg.sv
// Shared types for the conditional branch unit: condition codes, flag bit positions, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cond_branch_unit_pkg;

  // Condition codes as encoded in the B.cond instruction field.
  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_HS = 4'h2,
    CC_LO = 4'h3,
    CC_MI = 4'h4,
    CC_PL = 4'h5,
    CC_VS = 4'h6,
    CC_VC = 4'h7,
    CC_HI = 4'h8,
    CC_LS = 4'h9,
    CC_GE = 4'hA,
    CC_LT = 4'hB,
    CC_GT = 4'hC,
    CC_LE = 4'hD,
    CC_AL = 4'hE,
    CC_NV = 4'hF
  } cond_t;

  // Bit positions inside the 4-bit flags vector.
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  // REDIRECT is the single wrong-path cycle following a taken branch.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  // Statistics counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// Evaluates a condition code against a flags vector; pass=1 when the condition holds.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module cond_eval
  import cond_branch_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  // Condition-code truth table; AL and NV both mean "always".
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z;
      CC_NE:   pass = !z;
      CC_HS:   pass = c;
      CC_LO:   pass = !c;
      CC_MI:   pass = n;
      CC_PL:   pass = !n;
      CC_VS:   pass = v;
      CC_VC:   pass = !v;
      CC_HI:   pass = c & !z;
      CC_LS:   pass = !c | z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = !z & (n == v);
      CC_LE:   pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Resolves B / B.cond / CBZ in decode, emitting a registered redirect pulse and statistics.
// Latency: one cycle from decode inputs to br_taken_o / br_target_o / flush_o.
// Backpressure: none; the cycle after a taken branch is wrong-path and its decode input is dropped.
module cond_branch_unit
  import cond_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_is_b,
  input  logic        id_is_bcond,
  input  logic        id_is_cbz,
  input  logic [3:0]  id_cond,
  input  logic [63:0] id_pc,
  input  logic [25:0] id_imm,
  input  logic [63:0] id_rt_val,
  input  logic [3:0]  flags_q,
  input  logic        ex_flag_en,
  input  logic [3:0]  ex_flags,
  output logic        br_taken_o,
  output logic [63:0] br_target_o,
  output logic        flush_o,
  output logic [31:0] resolved_cnt_o,
  output logic [31:0] taken_cnt_o
);

  state_t      state_q, state_d;
  logic        taken_d, flush_d;
  logic [63:0] target_d;
  logic [31:0] res_cnt_d, tak_cnt_d;

  logic [3:0]  eff_flags;
  logic        cond_pass;
  logic        is_branch;
  logic        take;
  logic [63:0] offset;
  logic [63:0] target;

  // An ADDS/SUBS in EX overrides committed flags so B.cond never stalls.
  assign eff_flags = ex_flag_en ? ex_flags : flags_q;

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (id_cond),
    .pass  (cond_pass)
  );

  assign is_branch = id_is_b | id_is_bcond | id_is_cbz;

  // Class priority B > B.cond > CBZ decides both the taken test and offset width.
  always_comb begin
    take   = 1'b0;
    offset = {{45{id_imm[18]}}, id_imm[18:0]};
    if (id_is_b) begin
      take   = 1'b1;
      offset = {{38{id_imm[25]}}, id_imm};
    end else if (id_is_bcond) begin
      take   = cond_pass;
    end else if (id_is_cbz) begin
      take   = (id_rt_val == 64'd0);
    end
  end

  // Word-aligned offset; addition wraps naturally at 64 bits.
  assign target = id_pc + {offset[61:0], 2'b00};

  // Next-state and next-output logic; REDIRECT discards whatever decode presents.
  always_comb begin
    state_d   = state_q;
    taken_d   = 1'b0;
    flush_d   = 1'b0;
    target_d  = br_target_o;
    res_cnt_d = resolved_cnt_o;
    tak_cnt_d = taken_cnt_o;
    case (state_q)
      ST_IDLE: begin
        if (id_valid && is_branch) begin
          res_cnt_d = sat_inc(resolved_cnt_o);
          if (take) begin
            tak_cnt_d = sat_inc(taken_cnt_o);
            taken_d   = 1'b1;
            flush_d   = 1'b1;
            target_d  = target;
            state_d   = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset cancels any in-flight redirect pulse at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      br_taken_o     <= 1'b0;
      flush_o        <= 1'b0;
      br_target_o    <= 64'd0;
      resolved_cnt_o <= 32'd0;
      taken_cnt_o    <= 32'd0;
    end else begin
      state_q        <= state_d;
      br_taken_o     <= taken_d;
      flush_o        <= flush_d;
      br_target_o    <= target_d;
      resolved_cnt_o <= res_cnt_d;
      taken_cnt_o    <= tak_cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
module tb_cond_branch_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic        id_is_b;
  logic        id_is_bcond;
  logic        id_is_cbz;
  logic [3:0]  id_cond;
  logic [63:0] id_pc;
  logic [25:0] id_imm;
  logic [63:0] id_rt_val;
  logic [3:0]  flags_q;
  logic        ex_flag_en;
  logic [3:0]  ex_flags;
  logic        br_taken_o;
  logic [63:0] br_target_o;
  logic        flush_o;
  logic [31:0] resolved_cnt_o;
  logic [31:0] taken_cnt_o;

  int checks;
  int errors;
  logic [31:0] exp_res;
  logic [31:0] exp_tak;

  cond_branch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_is_b        (id_is_b),
    .id_is_bcond    (id_is_bcond),
    .id_is_cbz      (id_is_cbz),
    .id_cond        (id_cond),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .id_rt_val      (id_rt_val),
    .flags_q        (flags_q),
    .ex_flag_en     (ex_flag_en),
    .ex_flags       (ex_flags),
    .br_taken_o     (br_taken_o),
    .br_target_o    (br_target_o),
    .flush_o        (flush_o),
    .resolved_cnt_o (resolved_cnt_o),
    .taken_cnt_o    (taken_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one decode slot for a single clock, then sample 1 time unit after the edge.
  task automatic issue(input logic v, input logic b, input logic bc, input logic cz,
                       input logic [3:0] cond, input logic [63:0] pc, input logic [25:0] imm,
                       input logic [63:0] rt, input logic [3:0] fq, input logic en,
                       input logic [3:0] exf);
    id_valid    = v;
    id_is_b     = b;
    id_is_bcond = bc;
    id_is_cbz   = cz;
    id_cond     = cond;
    id_pc       = pc;
    id_imm      = imm;
    id_rt_val   = rt;
    flags_q     = fq;
    ex_flag_en  = en;
    ex_flags    = exf;
    @(posedge clk);
    #1;
    id_valid    = 1'b0;
    id_is_b     = 1'b0;
    id_is_bcond = 1'b0;
    id_is_cbz   = 1'b0;
    ex_flag_en  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Reference truth table, flags ordered [0]N [1]Z [2]V [3]C.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, v, c;
    n = f[0]; z = f[1]; v = f[2]; c = f[3];
    case (cc)
      4'h0: return z == 1'b1;
      4'h1: return z == 1'b0;
      4'h2: return c == 1'b1;
      4'h3: return c == 1'b0;
      4'h4: return n == 1'b1;
      4'h5: return n == 1'b0;
      4'h6: return v == 1'b1;
      4'h7: return v == 1'b0;
      4'h8: return (c == 1'b1) && (z == 1'b0);
      4'h9: return (c == 1'b0) || (z == 1'b1);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return (z == 1'b0) && (n == v);
      4'hD: return (z == 1'b1) || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_res"}, {32'd0, resolved_cnt_o}, {32'd0, exp_res});
    check({tag, "_tak"}, {32'd0, taken_cnt_o}, {32'd0, exp_tak});
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_res     = 32'd0;
    exp_tak     = 32'd0;
    reset       = 1'b1;
    id_valid    = 1'b0;
    id_is_b     = 1'b0;
    id_is_bcond = 1'b0;
    id_is_cbz   = 1'b0;
    id_cond     = 4'h0;
    id_pc       = 64'd0;
    id_imm      = 26'd0;
    id_rt_val   = 64'd0;
    flags_q     = 4'h0;
    ex_flag_en  = 1'b0;
    ex_flags    = 4'h0;

    #1 reset = 1'b0;
    #3;
    check("rst_taken",  {63'd0, br_taken_o}, 64'd0);
    check("rst_flush",  {63'd0, flush_o}, 64'd0);
    check("rst_target", br_target_o, 64'd0);
    check_counts("rst");
    @(negedge clk);
    reset = 1'b1;

    // Z set, EQ: taken to 0x1000 + 4*4.
    issue(1, 0, 1, 0, 4'h0, 64'h1000, 26'd4, 64'd0, 4'b0010, 0, 4'h0);
    exp_res++; exp_tak++;
    check("eq_taken",  {63'd0, br_taken_o}, 64'd1);
    check("eq_flush",  {63'd0, flush_o}, 64'd1);
    check("eq_target", br_target_o, 64'h1010);
    check_counts("eq");
    idle();
    check("pulse_taken",  {63'd0, br_taken_o}, 64'd0);
    check("pulse_flush",  {63'd0, flush_o}, 64'd0);
    check("hold_target",  br_target_o, 64'h1010);

    // Bypassed Z=1 wins over committed Z=0, so NE fails.
    issue(1, 0, 1, 0, 4'h1, 64'h2000, 26'd8, 64'd0, 4'b0000, 1, 4'b0010);
    exp_res++;
    check("byp_taken",  {63'd0, br_taken_o}, 64'd0);
    check("byp_flush",  {63'd0, flush_o}, 64'd0);
    check("byp_target", br_target_o, 64'h1010);
    check_counts("byp");

    // B with offset -1 word, then an AL branch in the wrong-path cycle is dropped.
    issue(1, 1, 0, 0, 4'h0, 64'h100, 26'h3FF_FFFF, 64'd0, 4'h0, 0, 4'h0);
    exp_res++; exp_tak++;
    check("b_taken",  {63'd0, br_taken_o}, 64'd1);
    check("b_target", br_target_o, 64'hFC);
    check_counts("b");
    issue(1, 0, 1, 0, 4'hE, 64'h5000, 26'd1, 64'd0, 4'h0, 0, 4'h0);
    check("drop_taken",  {63'd0, br_taken_o}, 64'd0);
    check("drop_flush",  {63'd0, flush_o}, 64'd0);
    check("drop_target", br_target_o, 64'hFC);
    check_counts("drop");

    // CBZ wrapping below zero, then CBZ on a nonzero register.
    issue(1, 0, 0, 1, 4'h0, 64'd0, 26'h007_FFFF, 64'd0, 4'h0, 0, 4'h0);
    exp_res++; exp_tak++;
    check("cbz0_taken",  {63'd0, br_taken_o}, 64'd1);
    check("cbz0_target", br_target_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check_counts("cbz0");
    idle();
    issue(1, 0, 0, 1, 4'h0, 64'd0, 26'h007_FFFF, 64'd5, 4'h0, 0, 4'h0);
    exp_res++;
    check("cbznz_taken",  {63'd0, br_taken_o}, 64'd0);
    check("cbznz_target", br_target_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check_counts("cbznz");

    // All class bits: B wins despite failing NE and nonzero Rt.
    issue(1, 1, 1, 1, 4'h1, 64'h40, 26'd2, 64'd7, 4'b0010, 0, 4'h0);
    exp_res++; exp_tak++;
    check("prio_b_taken",  {63'd0, br_taken_o}, 64'd1);
    check("prio_b_target", br_target_o, 64'h48);
    idle();
    // B.cond over CBZ: failing NE wins over CBZ that would be taken.
    issue(1, 0, 1, 1, 4'h1, 64'h80, 26'd2, 64'd0, 4'b0010, 0, 4'h0);
    exp_res++;
    check("prio_bc_taken", {63'd0, br_taken_o}, 64'd0);
    // Valid slot with no class bits, and a B with valid low: neither counted.
    issue(1, 0, 0, 0, 4'hE, 64'h80, 26'd2, 64'd0, 4'h0, 0, 4'h0);
    check("nobr_taken", {63'd0, br_taken_o}, 64'd0);
    issue(0, 1, 0, 0, 4'hE, 64'h80, 26'd2, 64'd0, 4'h0, 0, 4'h0);
    check("noval_taken", {63'd0, br_taken_o}, 64'd0);
    check_counts("prio");

    // Every condition against every flag value, half via the bypass path.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] fv;
        logic [3:0] cv;
        logic       exp_t;
        fv = f[3:0];
        cv = c[3:0];
        exp_t = ref_cond(fv, cv);
        if (((f + c) % 2) == 1)
          issue(1, 0, 1, 0, cv, 64'h0, 26'd1, 64'd0, ~fv, 1, fv);
        else
          issue(1, 0, 1, 0, cv, 64'h0, 26'd1, 64'd0, fv, 0, 4'h0);
        exp_res++;
        if (exp_t) exp_tak++;
        check($sformatf("cc%0h_f%0h", cv, fv), {63'd0, br_taken_o}, {63'd0, exp_t});
        idle();
      end
    end
    check_counts("sweep");

    // Reset in the middle of a redirect pulse.
    issue(1, 1, 0, 0, 4'h0, 64'h3000, 26'd3, 64'd0, 4'h0, 0, 4'h0);
    check("pre_rst_taken", {63'd0, br_taken_o}, 64'd1);
    #2 reset = 1'b0;
    #1;
    exp_res = 32'd0;
    exp_tak = 32'd0;
    check("mid_rst_taken",  {63'd0, br_taken_o}, 64'd0);
    check("mid_rst_flush",  {63'd0, flush_o}, 64'd0);
    check("mid_rst_target", br_target_o, 64'd0);
    check_counts("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    issue(1, 1, 0, 0, 4'h0, 64'h2000, 26'd1, 64'd0, 4'h0, 0, 4'h0);
    exp_res++; exp_tak++;
    check("post_rst_taken",  {63'd0, br_taken_o}, 64'd1);
    check("post_rst_target", br_target_o, 64'h2004);
    check_counts("post_rst");
    idle();
    check("post_rst_pulse", {63'd0, br_taken_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
